// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment digit buffer: digit-word layout,
// blank word, FSM state encoding and digit count.
package sseg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned HEX_W      = 4;

    localparam int unsigned EN_BIT  = 5;
    localparam int unsigned HEX_MSB = 4;
    localparam int unsigned HEX_LSB = 1;
    localparam int unsigned DP_BIT  = 0;

    localparam logic [5:0] BLANK      = 6'b000000;
    localparam logic [3:0] FULL_COUNT = 4'(NUM_DIGITS);

    typedef enum logic [0:0] {
        StIdle,
        StClearing
    } state_e;

    function automatic logic [5:0] make_word(input logic [HEX_W-1:0] hex, input logic dp);
        logic [5:0] w;
        w                  = BLANK;
        w[EN_BIT]          = 1'b1;
        w[HEX_MSB:HEX_LSB] = hex;
        w[DP_BIT]          = dp;
        return w;
    endfunction

endpackage

// File: rtl/sseg_digit_buffer_if.sv
// Character input channel of the digit buffer: valid/ready push plus
// single-cycle clear and backspace requests.
interface sseg_digit_buffer_if;
    import sseg_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [HEX_W-1:0] in_hex;
    logic             in_dp;
    logic             clear;
    logic             backspace;

    modport master (
        output in_valid, in_hex, in_dp, clear, backspace,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_hex, in_dp, clear, backspace,
        output in_ready
    );

endinterface

// File: rtl/timer_parameter.sv
// Free-running modulo counter; done pulses for one cycle when the count
// reaches FINAL_VALUE, restart forces the count back to zero.
module timer_parameter #(
    parameter int unsigned FINAL_VALUE = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic done
);

    localparam int unsigned W = (FINAL_VALUE > 0) ? $clog2(FINAL_VALUE + 1) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign done = enable && (cnt_q == W'(FINAL_VALUE));

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = done ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sseg_digit_buffer.sv
// Eight-digit shift buffer for a seven-segment driver with push, backspace and
// sequential clear. Optional I0 blinking is enabled with `define SSEG_BLINK_EN.
module sseg_digit_buffer
    import sseg_pkg::*;
#(
    parameter int unsigned BLINK_PERIOD = 25000000
) (
    input  logic                 clk,
    input  logic                 reset,
    sseg_digit_buffer_if.slave   in_if,
    output logic [5:0]           I0,
    output logic [5:0]           I1,
    output logic [5:0]           I2,
    output logic [5:0]           I3,
    output logic [5:0]           I4,
    output logic [5:0]           I5,
    output logic [5:0]           I6,
    output logic [5:0]           I7,
    output logic [3:0]           count
);

    state_e     state_q, state_d;
    logic [5:0] digits_q [NUM_DIGITS];
    logic [5:0] digits_d [NUM_DIGITS];
    logic [3:0] count_q, count_d;
    logic [2:0] clr_idx_q, clr_idx_d;
    logic       push;

    assign in_if.in_ready = (state_q == StIdle);

    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        count_d   = count_q;
        clr_idx_d = clr_idx_q;
        push      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_if.clear) begin
                    state_d   = StClearing;
                    clr_idx_d = 3'(NUM_DIGITS - 1);
                end else if (in_if.backspace) begin
                    if (count_q != 4'd0) begin
                        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
                            digits_d[i] = digits_q[i+1];
                        end
                        digits_d[NUM_DIGITS-1] = BLANK;
                        count_d = count_q - 4'd1;
                    end
                end else if (in_if.in_valid) begin
                    push = 1'b1;
                    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                        digits_d[i] = digits_q[i-1];
                    end
                    digits_d[0] = make_word(in_if.in_hex, in_if.in_dp);
                    if (count_q != FULL_COUNT) begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            StClearing: begin
                // Blank from the oldest slot down; count drops only once all are blank.
                digits_d[clr_idx_q] = BLANK;
                if (clr_idx_q == 3'd0) begin
                    state_d = StIdle;
                    count_d = 4'd0;
                end else begin
                    clr_idx_d = clr_idx_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= 4'd0;
            clr_idx_q <= 3'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_q[i] <= BLANK;
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            clr_idx_q <= clr_idx_d;
            digits_q  <= digits_d;
        end
    end

    assign count = count_q;
    assign I1    = digits_q[1];
    assign I2    = digits_q[2];
    assign I3    = digits_q[3];
    assign I4    = digits_q[4];
    assign I5    = digits_q[5];
    assign I6    = digits_q[6];
    assign I7    = digits_q[7];

`ifdef SSEG_BLINK_EN
    logic blink_tick;
    logic phase_q, phase_d;

    timer_parameter #(
        .FINAL_VALUE(BLINK_PERIOD - 1)
    ) u_blink_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (1'b1),
        .restart(push),
        .done   (blink_tick)
    );

    always_comb begin
        phase_d = phase_q;
        if (push) begin
            phase_d = 1'b1;
        end else if (blink_tick) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign I0 = {digits_q[0][EN_BIT] & phase_q, digits_q[0][EN_BIT-1:0]};
`else
    logic unused_blink;
    assign unused_blink = |BLINK_PERIOD | push;
    assign I0 = digits_q[0];
`endif

endmodule
